// File: rtl/dec_8b10b_pkg.sv
// Shared constants, disparity classes and the sub-block disparity helper
// for the 8b/10b receive decoder.
package dec_8b10b_pkg;

  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int C_IDX = 2;
  localparam int D_IDX = 3;
  localparam int E_IDX = 4;
  localparam int I_IDX = 5;
  localparam int F_IDX = 6;
  localparam int G_IDX = 7;
  localparam int H_IDX = 8;
  localparam int J_IDX = 9;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  // NEU keeps RD; SETP/SETN are neutral blocks that still force RD
  typedef enum logic [2:0] {
    DISP_NEU,
    DISP_POS,
    DISP_NEG,
    DISP_SETP,
    DISP_SETN
  } disp_e;

  // sb is {a,b,c,d,e,i} for 6b, or {2'b00,f,g,h,j} for 4b
  function automatic disp_e sb_disp(
    input logic [5:0] sb,
    input logic       is6
  );
    int    w;
    int    mid;
    disp_e r;
    w   = is6 ? $countones(sb) : $countones(sb[3:0]);
    mid = is6 ? 3 : 2;
    r   = DISP_NEU;
    if (w > mid) begin
      r = DISP_POS;
    end else if (w < mid) begin
      r = DISP_NEG;
    end else if (is6) begin
      if (sb == 6'b000111) r = DISP_SETP;
      if (sb == 6'b111000) r = DISP_SETN;
    end else begin
      if (sb[3:0] == 4'b0011) r = DISP_SETP;
      if (sb[3:0] == 4'b1100) r = DISP_SETN;
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_8b10b_rd.sv
// Combinational running-disparity step and rderr for one 10b symbol.
// Ports: rd_in, code6 {abcdei}, code4 {fghj} in; rd_out, rderr out. Only built with DEC8B10B_RDCHECK_EN.
`ifdef DEC8B10B_RDCHECK_EN
module dec_8b10b_rd (
  input  logic       rd_in,
  input  logic [5:0] code6,
  input  logic [3:0] code4,
  output logic       rd_out,
  output logic       rderr
);
  import dec_8b10b_pkg::*;

  disp_e d6;
  disp_e d4;
  logic  rd_mid;
  logic  e6;
  logic  e4;

  always_comb begin
    d6     = sb_disp(code6, 1'b1);
    d4     = sb_disp({2'b00, code4}, 1'b0);
    rd_mid = rd_in;
    rd_out = rd_in;
    unique case (d6)
      DISP_POS, DISP_SETP: rd_mid = 1'b1;
      DISP_NEG, DISP_SETN: rd_mid = 1'b0;
      default:             rd_mid = rd_in;
    endcase
    unique case (d4)
      DISP_POS, DISP_SETP: rd_out = 1'b1;
      DISP_NEG, DISP_SETN: rd_out = 1'b0;
      default:             rd_out = rd_mid;
    endcase
    e6    = ((d6 == DISP_POS) && rd_in) ||
            ((d6 == DISP_NEG) && !rd_in);
    e4    = ((d4 == DISP_POS) && rd_mid) ||
            ((d4 == DISP_NEG) && !rd_mid);
    rderr = e6 | e4;
  end

endmodule
`endif

// File: rtl/dec_8b10b.sv
// Registered 8b/10b decoder: datain (10b symbol), ena, RBYTECLK, RESET in;
// dataout, kout, kerr, rderr, rdout out. RD checking needs DEC8B10B_RDCHECK_EN.
module dec_8b10b (
  input  logic       RBYTECLK,
  input  logic       RESET,
  input  logic       ena,
  input  logic [9:0] datain,
  output logic [7:0] dataout,
  output logic       kout,
  output logic       kerr,
  output logic       rderr,
  output logic       rdout
);
  import dec_8b10b_pkg::*;

  logic [5:0] c6;
  logic [3:0] c4;
  logic [3:0] c4x;
  logic [4:0] d5;
  logic [2:0] d3;
  logic       v6;
  logic       v4;

  assign c6 = {datain[A_IDX], datain[B_IDX], datain[C_IDX],
               datain[D_IDX], datain[E_IDX], datain[I_IDX]};
  assign c4 = {datain[F_IDX], datain[G_IDX],
               datain[H_IDX], datain[J_IDX]};

  // K28 in its RD+ form carries the complement of the table 4b code
  assign c4x = (c6 == 6'b110000) ? ~c4 : c4;

  always_comb begin
    d5 = 5'd0;
    v6 = 1'b1;
    unique case (c6)
      6'b100111, 6'b011000: d5 = 5'd0;
      6'b011101, 6'b100010: d5 = 5'd1;
      6'b101101, 6'b010010: d5 = 5'd2;
      6'b110001:            d5 = 5'd3;
      6'b110101, 6'b001010: d5 = 5'd4;
      6'b101001:            d5 = 5'd5;
      6'b011001:            d5 = 5'd6;
      6'b111000, 6'b000111: d5 = 5'd7;
      6'b111001, 6'b000110: d5 = 5'd8;
      6'b100101:            d5 = 5'd9;
      6'b010101:            d5 = 5'd10;
      6'b110100:            d5 = 5'd11;
      6'b001101:            d5 = 5'd12;
      6'b101100:            d5 = 5'd13;
      6'b011100:            d5 = 5'd14;
      6'b010111, 6'b101000: d5 = 5'd15;
      6'b011011, 6'b100100: d5 = 5'd16;
      6'b100011:            d5 = 5'd17;
      6'b010011:            d5 = 5'd18;
      6'b110010:            d5 = 5'd19;
      6'b001011:            d5 = 5'd20;
      6'b101010:            d5 = 5'd21;
      6'b011010:            d5 = 5'd22;
      6'b111010, 6'b000101: d5 = 5'd23;
      6'b110011, 6'b001100: d5 = 5'd24;
      6'b100110:            d5 = 5'd25;
      6'b010110:            d5 = 5'd26;
      6'b110110, 6'b001001: d5 = 5'd27;
      6'b001110:            d5 = 5'd28;
      6'b101110, 6'b010001: d5 = 5'd29;
      6'b011110, 6'b100001: d5 = 5'd30;
      6'b101011, 6'b010100: d5 = 5'd31;
      6'b001111, 6'b110000: d5 = 5'd28;
      default: begin
        d5 = {c6[5], c6[4], c6[3], c6[2], c6[1]};
        v6 = 1'b0;
      end
    endcase
  end

  always_comb begin
    d3 = 3'd0;
    v4 = 1'b1;
    unique case (c4x)
      4'b1011, 4'b0100: d3 = 3'd0;
      4'b1001:          d3 = 3'd1;
      4'b0101:          d3 = 3'd2;
      4'b1100, 4'b0011: d3 = 3'd3;
      4'b1101, 4'b0010: d3 = 3'd4;
      4'b1010:          d3 = 3'd5;
      4'b0110:          d3 = 3'd6;
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: d3 = 3'd7;
      default: begin
        d3 = c4x[2:0];
        v4 = 1'b0;
      end
    endcase
  end

  logic k28_6;
  logic kx7p_6;
  logic kx7n_6;
  logic p7;
  logic a7p;
  logic a7n;
  logic a7p_ok;
  logic a7n_ok;
  logic run_err;
  logic k_hit;
  logic bad;

  assign k28_6  = c6 inside {6'b001111, 6'b110000};
  assign kx7p_6 = c6 inside {6'b000101, 6'b001001,
                             6'b010001, 6'b100001};
  assign kx7n_6 = c6 inside {6'b111010, 6'b110110,
                             6'b101110, 6'b011110};
  assign p7     = c4 inside {4'b1110, 4'b0001};
  assign a7p    = (c4 == 4'b0111);
  assign a7n    = (c4 == 4'b1000);

  // alternate x.7 only where primary would make a run of five
  assign a7p_ok = (c6 inside {6'b100011, 6'b010011, 6'b001011})
                | kx7p_6 | (c6 == 6'b110000);
  assign a7n_ok = (c6 inside {6'b110100, 6'b101100, 6'b011100})
                | kx7n_6 | (c6 == 6'b001111);

  // D.7 forms must not run on into a 4b group opening with d/e/i
  assign run_err = ((c6 == 6'b000111) && (c4[3:2] == 2'b11)) ||
                   ((c6 == 6'b111000) && (c4[3:2] == 2'b00));

  assign bad = !v6 | !v4 | run_err
             | (a7p & !a7p_ok) | (a7n & !a7n_ok)
             | (k28_6 & p7);

  assign k_hit = k28_6 | (kx7p_6 & a7p) | (kx7n_6 & a7n);

  logic [7:0] dataout_q, dataout_d;
  logic       kout_q, kout_d;
  logic       kerr_q, kerr_d;

  always_comb begin
    dataout_d = dataout_q;
    kout_d    = kout_q;
    kerr_d    = kerr_q;
    if (ena) begin
      dataout_d = {d3, d5};
      kout_d    = k_hit & !bad;
      kerr_d    = bad;
    end
  end

  always_ff @(posedge RBYTECLK) begin
    if (RESET) begin
      dataout_q <= 8'h00;
      kout_q    <= 1'b0;
      kerr_q    <= 1'b0;
    end else begin
      dataout_q <= dataout_d;
      kout_q    <= kout_d;
      kerr_q    <= kerr_d;
    end
  end

  assign dataout = dataout_q;
  assign kout    = kout_q;
  assign kerr    = kerr_q;

`ifdef DEC8B10B_RDCHECK_EN
  logic rd_q, rd_d;
  logic rderr_q, rderr_d;
  logic rd_nxt;
  logic rderr_nxt;

  dec_8b10b_rd u_rd (
    .rd_in  (rd_q),
    .code6  (c6),
    .code4  (c4),
    .rd_out (rd_nxt),
    .rderr  (rderr_nxt)
  );

  always_comb begin
    rd_d    = rd_q;
    rderr_d = rderr_q;
    if (ena) begin
      rd_d    = rd_nxt;
      rderr_d = rderr_nxt;
    end
  end

  always_ff @(posedge RBYTECLK) begin
    if (RESET) begin
      rd_q    <= 1'b0;
      rderr_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      rderr_q <= rderr_d;
    end
  end

  assign rdout = rd_q;
  assign rderr = rderr_q;
`else
  assign rdout = 1'b0;
  assign rderr = 1'b0;
`endif

endmodule

// File: tb/tb_dec_8b10b.sv
// Directed self-checking bench for dec_8b10b.
// RD expectations collapse to 0 when DEC8B10B_RDCHECK_EN is undefined.
module tb_dec_8b10b;

`ifdef DEC8B10B_RDCHECK_EN
  localparam logic RDC = 1'b1;
`else
  localparam logic RDC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic [9:0] din;
  logic [7:0] dout;
  logic       kout;
  logic       kerr;
  logic       rderr;
  logic       rdout;

  int checks = 0;
  int errors = 0;

  dec_8b10b dut (
    .RBYTECLK (clk),
    .RESET    (rst),
    .ena      (ena),
    .datain   (din),
    .dataout  (dout),
    .kout     (kout),
    .kerr     (kerr),
    .rderr    (rderr),
    .rdout    (rdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] e_d,
                         input logic e_k,
                         input logic e_ke,
                         input logic e_rde,
                         input logic e_rdo);
    chk({tag, ".dataout"}, dout, e_d);
    chk({tag, ".kout"}, {7'd0, kout}, {7'd0, e_k});
    chk({tag, ".kerr"}, {7'd0, kerr}, {7'd0, e_ke});
    chk({tag, ".rderr"}, {7'd0, rderr}, {7'd0, e_rde});
    chk({tag, ".rdout"}, {7'd0, rdout}, {7'd0, e_rdo});
  endtask

  task automatic sym(input logic [9:0] d, input logic e);
    din = d;
    ena = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    din = 10'h000;
    repeat (10) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;

    // D0.0 is neutral: RD- in, RD- out, both times
    sym(10'h0B9, 1'b1);
    chk_all("d0_0_a", 8'h00, 0, 0, 0, 0);
    sym(10'h0B9, 1'b1);
    chk_all("d0_0_b", 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        sym(10'h17C, 1'b1);
        chk_all("comma_n", 8'hBC, 1, 0, 0, RDC);
      end else begin
        sym(10'h283, 1'b1);
        chk_all("comma_p", 8'hBC, 1, 0, 0, 0);
      end
    end

    // D0.0 RD- form arriving while RD+
    sym(10'h17C, 1'b1);
    chk_all("pre_rderr", 8'hBC, 1, 0, 0, RDC);
    sym(10'h0B9, 1'b1);
    chk_all("rderr_d0", 8'h00, 0, 0, RDC, 0);

    // no combinational path: output still old before the edge
    din = 10'h2D6;
    ena = 1'b1;
    #2;
    chk("latency", dout, 8'h00);
    @(posedge clk);
    #1;
    chk_all("d22_4", 8'h96, 0, 0, 0, RDC);

    sym(10'h3FF, 1'b1);
    chk("ones.kerr", {7'd0, kerr}, 8'h01);
    chk("ones.kout", {7'd0, kout}, 8'h00);
    sym(10'h000, 1'b1);
    chk("zeros.kerr", {7'd0, kerr}, 8'h01);
    chk("zeros.kout", {7'd0, kout}, 8'h00);
    sym(10'h17C, 1'b1);
    chk_all("recover", 8'hBC, 1, 0, 0, RDC);

    sym(10'h283, 1'b0);
    chk_all("hold1", 8'hBC, 1, 0, 0, RDC);
    sym(10'h0B9, 1'b0);
    chk_all("hold2", 8'hBC, 1, 0, 0, RDC);
    sym(10'h3FF, 1'b0);
    chk_all("hold3", 8'hBC, 1, 0, 0, RDC);

    rst = 1'b1;
    sym(10'h0B9, 1'b0);
    chk_all("mid_reset", 8'h00, 0, 0, 0, 0);
    rst = 1'b0;

    sym(10'h17C, 1'b1);
    chk_all("post_rst", 8'hBC, 1, 0, 0, RDC);
    sym(10'h283, 1'b1);
    chk_all("post_rst2", 8'hBC, 1, 0, 0, 0);

    sym(10'h07C, 1'b1);
    chk_all("k28_7", 8'hFC, 1, 0, 0, 0);
    sym(10'h057, 1'b1);
    chk_all("k23_7", 8'hF7, 1, 0, 0, 0);
    sym(10'h217, 1'b1);
    chk_all("d23_7", 8'hF7, 0, 0, 0, 0);

    // alternate x.7 after D3 is not a legal combination
    sym(10'h3A3, 1'b1);
    chk("bad_a7.kerr", {7'd0, kerr}, 8'h01);
    chk("bad_a7.kout", {7'd0, kout}, 8'h00);

    // K28.1 in RD+ form uses the complemented 4b group
    sym(10'h183, 1'b1);
    chk_all("k28_1p", 8'h3C, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
